instr_fetch: RTL and testbench

//  Consumer side of the program-counter interface: takes the word address driven by the PC

---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/fetch_watchdog.sv | 31 +++
 rtl/instr_fetch.sv | 150 +++++++++++++++
 tb/tb_instr_fetch.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State codes, watchdog width and the default NOP instruction.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_DRAIN = 3'd3,
    FETCH_FULL  = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          WD_W      = 8;

endpackage

// File: rtl/fetch_watchdog.sv
// Bus watchdog: counts busy cycles since the last request launch
// and flags expiry when the count reaches WAIT_LIMIT.
module fetch_watchdog
  import instr_fetch_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WD_W-1:0] LIM = WD_W'(WAIT_LIMIT);

  logic [WD_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt == LIM);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC consumer, memory req/gnt/rvalid master,
// and single-entry holding register toward decode.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter logic [31:0] NOP_WORD   = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] pc_current,
  input  logic        pc_valid,
  input  logic        flush,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [29:0] instr_pc,
  output logic        fetch_stall,
  output logic        bus_err
);

  fetch_state_t r_state;
  fetch_state_t w_next;
  logic [29:0]  r_addr;
  logic [31:0]  r_instr;
  logic [29:0]  r_pc;
  logic         r_err;
  logic         w_load;
  logic         w_cap;
  logic         w_nop;
  logic         w_active;
  logic         w_exp;

  assign w_active = (r_state == FETCH_REQ)  ||
                    (r_state == FETCH_WAIT) ||
                    (r_state == FETCH_DRAIN);

  fetch_watchdog #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_load),
    .i_en     (w_active),
    .o_expired(w_exp)
  );

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_cap  = 1'b0;
    w_nop  = 1'b0;
    unique case (r_state)
      FETCH_IDLE: begin
        if (pc_valid && !flush) begin
          w_next = FETCH_REQ;
          w_load = 1'b1;
        end
      end
      FETCH_REQ: begin
        if (w_exp) begin
          w_next = FETCH_FULL;
          w_nop  = 1'b1;
        end else if (mem_gnt) begin
          w_next = flush ? FETCH_DRAIN : FETCH_WAIT;
        end else if (flush) begin
          w_load = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (w_exp) begin
          w_next = FETCH_FULL;
          w_nop  = 1'b1;
        end else if (mem_rvalid && flush) begin
          w_next = FETCH_REQ;
          w_load = 1'b1;
        end else if (mem_rvalid) begin
          w_next = FETCH_FULL;
          w_cap  = 1'b1;
        end else if (flush) begin
          w_next = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (w_exp) begin
          w_next = FETCH_IDLE;
        end else if (mem_rvalid) begin
          w_next = FETCH_REQ;
          w_load = 1'b1;
        end
      end
      FETCH_FULL: begin
        if (flush) begin
          w_next = FETCH_IDLE;
        end else if (instr_ready) begin
          w_next = pc_valid ? FETCH_REQ : FETCH_IDLE;
          w_load = pc_valid;
        end
      end
      default: w_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Timeout delivers a NOP tagged with the stuck address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_instr <= NOP_WORD;
      r_pc    <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_load) begin
        r_addr <= pc_current;
      end
      if (w_cap) begin
        r_instr <= mem_rdata;
        r_pc    <= r_addr;
      end else if (w_nop) begin
        r_instr <= NOP_WORD;
        r_pc    <= r_addr;
      end
      if (w_exp) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mem_req     = (r_state == FETCH_REQ) && !w_exp;
  assign mem_addr    = r_addr;
  assign instr_valid = (r_state == FETCH_FULL);
  assign instr_out   = r_instr;
  assign instr_pc    = r_pc;
  assign bus_err     = r_err;
  assign fetch_stall = !((r_state == FETCH_IDLE) ||
                         ((r_state == FETCH_FULL) && instr_ready && !flush));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal checks,
// then random traffic compared every cycle against a behavioural model.
module tb_instr_fetch;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] pc_current;
  logic        pc_valid;
  logic        flush;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [29:0] instr_pc;
  logic        fetch_stall;
  logic        bus_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit auto_mem = 1'b0;
  int          q_due[$];
  logic [29:0] q_addr[$];

  always #5 clk = ~clk;

  instr_fetch #(
    .WAIT_LIMIT(LIM),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_current (pc_current),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .fetch_stall(fetch_stall),
    .bus_err    (bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: what the fetch unit is doing, as plain flags.
  bit          m_pend, m_gntd, m_orph, m_held, m_err;
  logic [29:0] m_addr, m_pc;
  logic [31:0] m_out;
  int          m_age;

  always @(posedge clk or posedge rst) begin
    bit act, ex, ld;
    if (rst) begin
      m_pend = 0; m_gntd = 0; m_orph = 0; m_held = 0; m_err = 0;
      m_addr = '0; m_pc = '0; m_out = 32'h0; m_age = 0;
    end else begin
      act = m_pend || m_gntd || m_orph;
      ex  = act && (m_age == LIM);
      ld  = 0;
      if (ex) begin
        m_err = 1;
        if (!m_orph) begin
          m_held = 1; m_out = 32'h0; m_pc = m_addr;
        end
        m_pend = 0; m_gntd = 0; m_orph = 0;
      end else if (m_pend) begin
        if (mem_gnt) begin
          m_pend = 0;
          if (flush) m_orph = 1; else m_gntd = 1;
        end else if (flush) ld = 1;
      end else if (m_gntd) begin
        if (mem_rvalid) begin
          m_gntd = 0;
          if (flush) begin
            m_pend = 1; ld = 1;
          end else begin
            m_held = 1; m_out = mem_rdata; m_pc = m_addr;
          end
        end else if (flush) begin
          m_gntd = 0; m_orph = 1;
        end
      end else if (m_orph) begin
        if (mem_rvalid) begin
          m_orph = 0; m_pend = 1; ld = 1;
        end
      end else if (m_held) begin
        if (flush) m_held = 0;
        else if (instr_ready) begin
          m_held = 0;
          if (pc_valid) begin
            m_pend = 1; ld = 1;
          end
        end
      end else if (pc_valid && !flush) begin
        m_pend = 1; ld = 1;
      end
      if (ld) begin
        m_addr = pc_current; m_age = 0;
      end else if (act) m_age++;
    end
  end

  always @(negedge clk) begin
    bit act, ex, idle, go;
    if (!rst) begin
      act  = m_pend || m_gntd || m_orph;
      ex   = act && (m_age == LIM);
      idle = !act && !m_held;
      go   = idle || (m_held && instr_ready && !flush);
      chk("mem_req", 32'(mem_req), 32'(m_pend && !ex));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("instr_valid", 32'(instr_valid), 32'(m_held));
      chk("instr_out", instr_out, m_out);
      chk("instr_pc", 32'(instr_pc), 32'(m_pc));
      chk("fetch_stall", 32'(fetch_stall), 32'(!go));
      chk("bus_err", 32'(bus_err), 32'(m_err));
    end
  end

  task automatic tick();
    bit g;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_mem) begin
      g = mem_req && ($urandom_range(0, 3) != 0);
      mem_gnt = g;
      if (g) begin
        q_due.push_back(cyc + int'($urandom_range(1, 3)));
        q_addr.push_back(mem_addr);
      end
      mem_rvalid = 1'b0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {q_addr[0], 2'b01} ^ 32'h5A5A_0000;
        void'(q_due.pop_front());
        void'(q_addr.pop_front());
      end else if (q_due.size() == 0 && $urandom_range(0, 15) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end
    end
  endtask

  initial begin
    rst = 1'b1; pc_current = '0; pc_valid = 0; flush = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; instr_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_out", instr_out, 32'h0);
    chk("rst_pc", 32'(instr_pc), 32'h0);
    chk("rst_err", 32'(bus_err), 32'h0);
    chk("rst_stall", 32'(fetch_stall), 32'h0);

    // basic fetch, 2-cycle latency
    pc_valid = 1; pc_current = 30'h100; instr_ready = 1; tick();
    chk("t1_req", 32'(mem_req), 32'h1);
    chk("t1_addr", 32'(mem_addr), 32'h100);
    chk("t1_stall_req", 32'(fetch_stall), 32'h1);
    mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h2408_000A; tick();
    mem_rvalid = 0;
    chk("t1_valid", 32'(instr_valid), 32'h1);
    chk("t1_out", instr_out, 32'h2408_000A);
    chk("t1_pc", 32'(instr_pc), 32'h100);
    chk("t1_model_out", m_out, 32'h2408_000A);
    chk("t1_stall_full", 32'(fetch_stall), 32'h0);
    pc_current = 30'h101; tick();
    chk("t1_stall_next", 32'(fetch_stall), 32'h1);
    chk("t1_addr2", 32'(mem_addr), 32'h101);

    // decoder backpressure
    mem_gnt = 1; instr_ready = 0; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1111_1111; tick();
    mem_rvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 32'(instr_valid), 32'h1);
      chk("t2_out", instr_out, 32'h1111_1111);
      chk("t2_stall", 32'(fetch_stall), 32'h1);
      chk("t2_req", 32'(mem_req), 32'h0);
      tick();
    end
    instr_ready = 1; pc_valid = 0; tick();
    chk("t2_idle", 32'(instr_valid), 32'h0);

    // flush in WAIT, orphan response later
    pc_valid = 1; pc_current = 30'h180; tick();
    mem_gnt = 1; tick();
    mem_gnt = 0; flush = 1; pc_current = 30'h200; tick();
    flush = 0; tick();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF; tick();
    mem_rvalid = 0;
    chk("t3_req", 32'(mem_req), 32'h1);
    chk("t3_addr", 32'(mem_addr), 32'h200);
    chk("t3_valid", 32'(instr_valid), 32'h0);
    mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h3333_3333; tick();
    mem_rvalid = 0;
    chk("t3_out", instr_out, 32'h3333_3333);
    chk("t3_pc", 32'(instr_pc), 32'h200);

    // flush and rvalid together
    pc_current = 30'h300; tick();
    mem_gnt = 1; tick();
    mem_gnt = 0; flush = 1; mem_rvalid = 1; mem_rdata = 32'h4444_4444;
    pc_current = 30'h340; tick();
    flush = 0; mem_rvalid = 0;
    chk("t4_req", 32'(mem_req), 32'h1);
    chk("t4_addr", 32'(mem_addr), 32'h340);
    chk("t4_valid", 32'(instr_valid), 32'h0);
    mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h5555_5555; tick();
    mem_rvalid = 0;
    chk("t4_out", instr_out, 32'h5555_5555);
    chk("t4_pc", 32'(instr_pc), 32'h340);
    pc_valid = 0; tick();

    // watchdog with gnt withheld
    pc_valid = 1; pc_current = 30'h400; tick();
    for (int i = 0; i < 4; i++) begin
      chk("t5_req", 32'(mem_req), 32'h1);
      chk("t5_err0", 32'(bus_err), 32'h0);
      tick();
    end
    chk("t5_req_drop", 32'(mem_req), 32'h0);
    instr_ready = 0; tick();
    chk("t5_err", 32'(bus_err), 32'h1);
    chk("t5_model_err", 32'(m_err), 32'h1);
    chk("t5_valid", 32'(instr_valid), 32'h1);
    chk("t5_nop", instr_out, 32'h0);
    chk("t5_pc", 32'(instr_pc), 32'h400);
    instr_ready = 1; pc_current = 30'h410; tick();
    mem_gnt = 1; tick();
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h6666_6666; tick();
    mem_rvalid = 0;
    chk("t5_out2", instr_out, 32'h6666_6666);
    chk("t5_sticky", 32'(bus_err), 32'h1);

    // reset in WAIT, late response ignored
    pc_current = 30'h500; tick();
    mem_gnt = 1; tick();
    mem_gnt = 0; rst = 1; tick();
    rst = 0; pc_valid = 0; mem_rvalid = 1; mem_rdata = 32'h7777_7777; tick();
    mem_rvalid = 0;
    chk("t6_valid", 32'(instr_valid), 32'h0);
    chk("t6_req", 32'(mem_req), 32'h0);
    chk("t6_addr", 32'(mem_addr), 32'h0);
    chk("t6_out", instr_out, 32'h0);
    chk("t6_pc", 32'(instr_pc), 32'h0);
    chk("t6_err", 32'(bus_err), 32'h0);
    chk("t6_stall", 32'(fetch_stall), 32'h0);

    // random traffic against the model
    auto_mem = 1'b1;
    repeat (3000) begin
      pc_valid    = ($urandom_range(0, 3) != 0);
      pc_current  = 30'($urandom);
      flush       = ($urandom_range(0, 9) == 0);
      instr_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    auto_mem = 1'b0;
    pc_valid = 0; flush = 0; mem_gnt = 0; mem_rvalid = 0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
